debug_dump_unit: RTL and testbench
==================================

Name: debug_dump_unit

Overview:
- Read-out side of the debug interface. The byte-wide write port loads instruction memory; this block is the reverse direction.
- After the pipeline halts, it reads the PC, all 32 bank registers and the first N_MEM_WORDS data-memory words.
- It serializes them as a byte stream over a valid/ready handshake toward the UART transmitter.
- It sits beside the debug unit and owns the register-bank and data-memory debug read ports while busy.

Parameters:
NB_PC, 32, PC width
NB_DATA, 32, register/memory word width (multiple of 8)
NB_REG, 5, register-bank address width
NB_ADDR, 32, data-memory word-address width
NB_MEM_WIDTH, 8, output byte width
N_REGS, 32, registers dumped
N_MEM_WORDS, 32, data-memory words dumped

Ports:
i_clock  in  1  system clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_start  in  1  start-dump request, honoured only in IDLE
i_pc  in  NB_PC  current PC, sampled on accepted start
o_reg_read_enable  in/out: out  1  register-bank debug read strobe
o_reg_addr  out  NB_REG  register index
i_reg_data  in  NB_DATA  register data, valid cycle after strobe
o_mem_read_enable  out  1  data-memory debug read strobe
o_mem_addr  out  NB_ADDR  data-memory word index
i_mem_data  in  NB_DATA  memory data, valid cycle after strobe
o_tx_data  out  NB_MEM_WIDTH  byte to transmitter
o_tx_valid  out  1  byte valid
i_tx_ready  in  1  transmitter accepts byte
o_busy  out  1  dump in progress
o_done  out  1  one-cycle pulse after last byte accepted

Behaviour:
- Reset (async, active-high):
  - state IDLE.
  - All outputs 0: o_tx_valid, o_busy, o_done, both read enables, addresses, o_tx_data.
  - All counters and the word register cleared.
- Frame: PC, R0..R(N_REGS-1), M0..M(N_MEM_WORDS-1). Each word is sent as NB_DATA/8 bytes, MSB first. Default frame = 260 bytes.
- Transfer rule: a byte transfers on a rising edge where o_tx_valid && i_tx_ready.
  - o_tx_data must stay stable while o_tx_valid=1 and the byte is not yet accepted.
  - o_tx_valid never drops without a transfer, except on reset.
- FSM states: IDLE, SEND, REQ, WAIT, DONE.
  - IDLE: on i_start=1, capture i_pc into the word register, set section=PC, go to SEND. o_busy rises next cycle.
  - SEND: o_tx_valid=1, o_tx_data = current byte of the word register. On transfer:
    - if the byte is not the last of the word, increment the byte index;
    - else if more words remain, reset the byte index and go to REQ;
    - else go to DONE.
  - REQ (1 cycle):
    - Section REG: assert o_reg_read_enable with o_reg_addr = index.
    - Section MEM: assert o_mem_read_enable with o_mem_addr = index.
    - Go to WAIT.
  - WAIT (1 cycle): capture i_reg_data or i_mem_data into the word register, then go to SEND.
  - DONE: o_done=1 for exactly one cycle, o_busy=0, go to IDLE.
- Section advance:
  - After the PC, go to REG with index 0.
  - After register N_REGS-1, go to MEM with index 0.
  - After memory word N_MEM_WORDS-1, the frame is complete.
  - If N_MEM_WORDS=0, MEM is skipped.
- Latency with i_tx_ready tied to 1:
  - first o_tx_valid appears the cycle after start is sampled;
  - PC bytes take 4 cycles;
  - each further word takes 6 cycles (REQ, WAIT, 4 × SEND);
  - o_done pulses 389 cycles after the start edge (default parameters).
- i_start while not in IDLE: ignored, with no restart or glitch.
- Reset mid-dump: immediate abort to IDLE with o_tx_valid=0. No partial-frame recovery; the next i_start begins a fresh frame.
- Read strobes are asserted only in REQ, never in two consecutive cycles.

Decomposition:
- Package debug_pkg:
  - state encoding (IDLE/SEND/REQ/WAIT/DONE);
  - section encoding (SEC_PC/SEC_REG/SEC_MEM);
  - BYTES_PER_WORD = NB_DATA/NB_MEM_WIDTH;
  - frame-length constant function.
- Sub-module word_serializer:
  - loads one NB_DATA word and emits BYTES_PER_WORD bytes MSB-first under valid/ready;
  - reports "last byte accepted";
  - the top FSM handles sequencing and read ports.

Test Plan:
1. Reset held → all outputs 0. Release with i_start=0 for 10 cycles → o_tx_valid, o_busy and the read enables stay 0.
2. i_pc=0x0000_0040, Rk=k, Mk=0xA5000000+k, ready=1, pulse start → 260 bytes starting 00 00 00 40, 00 00 00 00, 00 00 00 01…, ending A5 00 00 1F; o_done pulses 389 cycles after start.
3. Ready toggled pseudo-randomly (≈50%) → identical byte sequence to test 2; o_tx_data never changes while valid && !ready.
4. i_start pulsed again at byte 20 and byte 150 → stream unchanged, exactly one o_done.
5. i_reset asserted during R10 transfer → o_tx_valid=0 asynchronously, state IDLE; a new start yields a full 260-byte frame from the PC.
6. Check read strobes → exactly 32 o_reg_read_enable pulses with addresses 0..31 and 32 o_mem_read_enable pulses with addresses 0..31, each followed by one non-strobe cycle.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared types and helpers for the debug dump path: FSM and section
// encodings, plus word/frame sizing helpers.
package debug_pkg;

    // Dump sequencer states.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEND = 3'd1,
        REQ  = 3'd2,
        WAIT = 3'd3,
        DONE = 3'd4
    } state_t;

    // Which part of the frame the word register currently holds.
    typedef enum logic [1:0] {
        SEC_PC  = 2'd0,
        SEC_REG = 2'd1,
        SEC_MEM = 2'd2
    } section_t;

    // Number of output bytes that make up one data word.
    function automatic int bytes_per_word(input int nb_data, input int nb_byte);
        return nb_data / nb_byte;
    endfunction

    // Total bytes in one dump frame: PC word, register words, memory words.
    function automatic int frame_bytes(input int n_regs, input int n_mem_words,
                                       input int nb_data, input int nb_byte);
        return (1 + n_regs + n_mem_words) * bytes_per_word(nb_data, nb_byte);
    endfunction

endpackage

// File: rtl/debug_dump_unit_if.sv
// Bus bundle between the dump unit and its environment: the byte stream
// toward the UART transmitter and the register-bank / data-memory debug
// read ports.
//
// Stream handshake: a byte moves on a rising clock edge where tx_valid and
// tx_ready are both 1. While tx_valid is 1 and the byte has not moved,
// tx_data holds steady and tx_valid stays high (only reset may drop it).
// tx_ready may change freely and never feeds back into tx_valid/tx_data.
//
// Read ports: a one-cycle read_enable strobe with its address; the read
// data is expected on the cycle after the strobe.
interface debug_dump_unit_if #(
    parameter int NB_DATA      = 32,
    parameter int NB_REG       = 5,
    parameter int NB_ADDR      = 32,
    parameter int NB_MEM_WIDTH = 8
);
    logic [NB_MEM_WIDTH-1:0] tx_data;
    logic                    tx_valid;
    logic                    tx_ready;

    logic                    reg_read_enable;
    logic [NB_REG-1:0]       reg_addr;
    logic [NB_DATA-1:0]      reg_data;

    logic                    mem_read_enable;
    logic [NB_ADDR-1:0]      mem_addr;
    logic [NB_DATA-1:0]      mem_data;

    // Dump unit side.
    modport master (
        output tx_data, tx_valid,
        input  tx_ready,
        output reg_read_enable, reg_addr,
        input  reg_data,
        output mem_read_enable, mem_addr,
        input  mem_data
    );

    // Transmitter / register bank / data memory side.
    modport slave (
        input  tx_data, tx_valid,
        output tx_ready,
        input  reg_read_enable, reg_addr,
        output reg_data,
        input  mem_read_enable, mem_addr,
        output mem_data
    );
endinterface

// File: rtl/word_serializer.sv
// Holds one data word and presents it as a sequence of bytes, most
// significant byte first. The byte index advances on each accepted byte
// and wraps to zero after the last one, which is flagged to the sequencer.
module word_serializer
    import debug_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [NB_DATA-1:0] load_data,
    input  logic               valid,
    input  logic               ready,
    output logic [NB_BYTE-1:0] tx_data,
    output logic               last_accepted
);
    localparam int BPW   = bytes_per_word(NB_DATA, NB_BYTE);
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [NB_DATA-1:0] word_q;
    logic [IDX_W-1:0]   byte_idx;
    logic               is_last;

    assign is_last       = (byte_idx == IDX_W'(BPW - 1));
    assign last_accepted = valid && ready && is_last;

    // Word register and byte index: load restarts at the MSB, each accepted
    // byte steps to the next one, the last one wraps back to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q   <= '0;
            byte_idx <= '0;
        end else if (load) begin
            word_q   <= load_data;
            byte_idx <= '0;
        end else if (valid && ready) begin
            if (is_last) begin
                byte_idx <= '0;
            end else begin
                byte_idx <= byte_idx + 1'b1;
            end
        end
    end

    // Byte select: index 0 is the most significant byte of the word.
    always_comb begin
        tx_data = '0;
        for (int b = 0; b < BPW; b++) begin
            if (byte_idx == IDX_W'(b)) begin
                tx_data = word_q[(BPW-1-b)*NB_BYTE +: NB_BYTE];
            end
        end
    end

endmodule

// File: rtl/debug_dump_unit.sv
// Debug read-out sequencer. On start it captures the PC, then fetches every
// register and the leading data-memory words through the debug read ports
// and streams each word out byte by byte toward the UART transmitter.
// Frame order: PC, R0..R(N_REGS-1), M0..M(N_MEM_WORDS-1).
module debug_dump_unit
    import debug_pkg::*;
#(
    parameter int NB_PC        = 32,
    parameter int NB_DATA      = 32,
    parameter int NB_REG       = 5,
    parameter int NB_ADDR      = 32,
    parameter int NB_MEM_WIDTH = 8,
    parameter int N_REGS       = 32,
    parameter int N_MEM_WORDS  = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [NB_PC-1:0] i_pc,
    output logic             o_busy,
    output logic             o_done,
    output state_t           o_dbg_state,
    debug_dump_unit_if.master bus
);
    state_t      state_q;
    state_t      state_d;
    section_t    sec_q;
    logic [31:0] idx_q;

    // Where the frame goes after the word currently being sent.
    logic        has_next;
    section_t    next_sec;
    logic [31:0] next_idx;

    logic               start_accept;
    logic               ser_load;
    logic [NB_DATA-1:0] ser_load_data;
    logic               ser_valid;
    logic               last_accepted;

    assign start_accept = (state_q == IDLE) && i_start;
    assign o_dbg_state  = state_q;

    // The PC is captured on an accepted start; fetched words land in WAIT,
    // the cycle after the read strobe.
    assign ser_load      = start_accept || (state_q == WAIT);
    assign ser_load_data = (state_q == WAIT)
                         ? ((sec_q == SEC_MEM) ? bus.mem_data : bus.reg_data)
                         : NB_DATA'(i_pc);

    word_serializer #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_MEM_WIDTH)
    ) u_serializer (
        .clk           (i_clock),
        .rst           (i_reset),
        .load          (ser_load),
        .load_data     (ser_load_data),
        .valid         (ser_valid),
        .ready         (bus.tx_ready),
        .tx_data       (bus.tx_data),
        .last_accepted (last_accepted)
    );

    // Section walk: PC -> registers -> memory, skipping empty sections.
    always_comb begin
        has_next = 1'b0;
        next_sec = sec_q;
        next_idx = '0;
        case (sec_q)
            SEC_PC: begin
                if (N_REGS > 0) begin
                    has_next = 1'b1;
                    next_sec = SEC_REG;
                end else if (N_MEM_WORDS > 0) begin
                    has_next = 1'b1;
                    next_sec = SEC_MEM;
                end
            end
            SEC_REG: begin
                if ((idx_q + 32'd1) < 32'(N_REGS)) begin
                    has_next = 1'b1;
                    next_idx = idx_q + 32'd1;
                end else if (N_MEM_WORDS > 0) begin
                    has_next = 1'b1;
                    next_sec = SEC_MEM;
                end
            end
            SEC_MEM: begin
                if ((idx_q + 32'd1) < 32'(N_MEM_WORDS)) begin
                    has_next = 1'b1;
                    next_idx = idx_q + 32'd1;
                end
            end
            default: begin
                has_next = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Section and word index; advanced as the last byte of a word leaves so
    // that REQ already addresses the next word.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            sec_q <= SEC_PC;
            idx_q <= '0;
        end else if (start_accept) begin
            sec_q <= SEC_PC;
            idx_q <= '0;
        end else if ((state_q == SEND) && last_accepted && has_next) begin
            sec_q <= next_sec;
            idx_q <= next_idx;
        end
    end

    // Next-state logic; a start outside IDLE has no effect.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (last_accepted) begin
                    state_d = has_next ? REQ : DONE;
                end
            end
            REQ:     state_d = WAIT;
            WAIT:    state_d = SEND;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state: strobes only in REQ, valid only in SEND.
    always_comb begin
        ser_valid           = 1'b0;
        bus.tx_valid        = 1'b0;
        bus.reg_read_enable = 1'b0;
        bus.reg_addr        = '0;
        bus.mem_read_enable = 1'b0;
        bus.mem_addr        = '0;
        o_busy              = 1'b0;
        o_done              = 1'b0;
        case (state_q)
            SEND: begin
                ser_valid    = 1'b1;
                bus.tx_valid = 1'b1;
                o_busy       = 1'b1;
            end
            REQ: begin
                o_busy = 1'b1;
                if (sec_q == SEC_REG) begin
                    bus.reg_read_enable = 1'b1;
                    bus.reg_addr        = idx_q[NB_REG-1:0];
                end else if (sec_q == SEC_MEM) begin
                    bus.mem_read_enable = 1'b1;
                    bus.mem_addr        = NB_ADDR'(idx_q);
                end
            end
            WAIT: begin
                o_busy = 1'b1;
            end
            DONE: begin
                o_done = 1'b1;
            end
            default: begin
                o_busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_debug_dump_unit.sv
// Bench for debug_dump_unit: a table of dump scenarios (ready pattern,
// stray starts, mid-frame reset, data pattern) is run against a reference
// byte queue built straight from the frame layout, plus reset and idle
// sequences written out by hand.
module tb_debug_dump_unit;
    import debug_pkg::*;

    localparam int NB_PC   = 32;
    localparam int NB_DATA = 32;
    localparam int NB_REG  = 5;
    localparam int NB_ADDR = 32;
    localparam int NB_B    = 8;
    localparam int N_REGS  = 32;
    localparam int N_MEM   = 32;
    localparam int LIMIT   = 4000;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [NB_PC-1:0] pc;
    logic             busy;
    logic             done;
    state_t           dbg_state;

    debug_dump_unit_if #(
        .NB_DATA(NB_DATA), .NB_REG(NB_REG), .NB_ADDR(NB_ADDR), .NB_MEM_WIDTH(NB_B)
    ) bus ();

    debug_dump_unit #(
        .NB_PC(NB_PC), .NB_DATA(NB_DATA), .NB_REG(NB_REG), .NB_ADDR(NB_ADDR),
        .NB_MEM_WIDTH(NB_B), .N_REGS(N_REGS), .N_MEM_WORDS(N_MEM)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_start     (start),
        .i_pc        (pc),
        .o_busy      (busy),
        .o_done      (done),
        .o_dbg_state (dbg_state),
        .bus         (bus.master)
    );

    // Clock.
    always #5 clk = ~clk;

    // Register bank and data memory models: data one cycle after the strobe.
    logic [NB_DATA-1:0] regs_m [N_REGS];
    logic [NB_DATA-1:0] mem_m  [N_MEM];

    always @(posedge clk) begin
        if (bus.reg_read_enable) bus.reg_data <= regs_m[bus.reg_addr];
        if (bus.mem_read_enable) bus.mem_data <= mem_m[bus.mem_addr[4:0]];
    end

    // Scoreboard state.
    int checks = 0;
    int errors = 0;
    logic [NB_B-1:0] exp_q[$];

    typedef struct {
        int          ready_pct;
        int          restart_a;
        int          restart_b;
        int          abort_at;
        bit          rand_data;
        logic [31:0] pc;
        int          exp_bytes;
        int          exp_done;
        int          exp_latency;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference frame: PC word, then registers, then memory, each MSB first.
    task automatic build_frame(input logic [31:0] pc_w);
        logic [31:0] words[$];
        exp_q.delete();
        words.push_back(pc_w);
        for (int k = 0; k < N_REGS; k++) words.push_back(regs_m[k]);
        for (int k = 0; k < N_MEM; k++) words.push_back(mem_m[k]);
        foreach (words[w]) begin
            for (int b = NB_DATA / NB_B - 1; b >= 0; b--) begin
                exp_q.push_back(words[w][b*NB_B +: NB_B]);
            end
        end
    endtask

    task automatic load_model(input bit rnd);
        for (int k = 0; k < N_REGS; k++) regs_m[k] = rnd ? $urandom : 32'(k);
        for (int k = 0; k < N_MEM; k++) mem_m[k] = rnd ? $urandom : (32'hA500_0000 + 32'(k));
    endtask

    // Drive one dump scenario and check every cycle until done (or abort).
    task automatic run_vec(input vec_t v, input int vi);
        int   bytes_sent  = 0;
        int   done_count  = 0;
        int   done_cycle  = -1;
        int   reg_strobes = 0;
        int   mem_strobes = 0;
        int   cyc         = 0;
        bit   prev_hold   = 0;
        bit   prev_strobe = 0;
        bit   ra_done     = 0;
        bit   rb_done     = 0;
        bit   aborted     = 0;
        bit   finished    = 0;
        logic [NB_B-1:0] prev_data = '0;
        logic [NB_B-1:0] exp_b;

        load_model(v.rand_data);
        pc = v.pc;
        build_frame(v.pc);

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check($sformatf("v%0d_busy_after_start", vi), busy, 1);
        check($sformatf("v%0d_valid_after_start", vi), bus.tx_valid, 1);

        while (!finished && cyc < LIMIT) begin
            start = 1'b0;
            if (v.restart_a >= 0 && !ra_done && bytes_sent == v.restart_a) begin
                start = 1'b1; ra_done = 1;
            end
            if (v.restart_b >= 0 && !rb_done && bytes_sent == v.restart_b) begin
                start = 1'b1; rb_done = 1;
            end
            if (v.abort_at >= 0 && bytes_sent == v.abort_at && bus.tx_valid) begin
                rst = 1'b1;
                #1;
                check($sformatf("v%0d_abort_valid", vi), bus.tx_valid, 0);
                check($sformatf("v%0d_abort_busy", vi), busy, 0);
                check($sformatf("v%0d_abort_state", vi), 32'(dbg_state), 32'(IDLE));
                aborted  = 1;
                finished = 1;
                start    = 1'b0;
                @(negedge clk); rst = 1'b0;
            end else begin
                bus.tx_ready = ($urandom_range(99) < v.ready_pct);
                if (prev_hold) begin
                    check($sformatf("v%0d_hold_valid", vi), bus.tx_valid, 1);
                    check($sformatf("v%0d_hold_data", vi), bus.tx_data, prev_data);
                end
                if (bus.tx_valid && bus.tx_ready) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("v%0d_extra_byte", vi), 32'(bytes_sent), 32'(v.exp_bytes));
                    end else begin
                        exp_b = exp_q.pop_front();
                        check($sformatf("v%0d_byte%0d", vi, bytes_sent), bus.tx_data, exp_b);
                    end
                    bytes_sent++;
                end
                prev_hold = bus.tx_valid && !bus.tx_ready;
                prev_data = bus.tx_data;
                if (bus.reg_read_enable) begin
                    check($sformatf("v%0d_reg_addr", vi), 32'(bus.reg_addr), 32'(reg_strobes));
                    check($sformatf("v%0d_reg_gap", vi), prev_strobe, 0);
                    reg_strobes++;
                end
                if (bus.mem_read_enable) begin
                    check($sformatf("v%0d_mem_addr", vi), bus.mem_addr, 32'(mem_strobes));
                    check($sformatf("v%0d_mem_gap", vi), prev_strobe, 0);
                    check($sformatf("v%0d_mem_after_regs", vi), 32'(reg_strobes), 32'(N_REGS));
                    mem_strobes++;
                end
                prev_strobe = bus.reg_read_enable || bus.mem_read_enable;
                if (done) begin
                    done_count++;
                    if (done_cycle < 0) done_cycle = cyc + 1;
                end
                if (done_cycle >= 0 && cyc + 1 >= done_cycle + 4) finished = 1;
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;

        check($sformatf("v%0d_bytes", vi), 32'(bytes_sent), 32'(v.exp_bytes));
        check($sformatf("v%0d_done_count", vi), 32'(done_count), 32'(v.exp_done));
        if (v.exp_latency >= 0)
            check($sformatf("v%0d_done_cycle", vi), 32'(done_cycle), 32'(v.exp_latency));
        if (!aborted) begin
            check($sformatf("v%0d_reg_strobes", vi), 32'(reg_strobes), 32'(N_REGS));
            check($sformatf("v%0d_mem_strobes", vi), 32'(mem_strobes), 32'(N_MEM));
            check($sformatf("v%0d_left_bytes", vi), 32'(exp_q.size()), 0);
            check($sformatf("v%0d_end_busy", vi), busy, 0);
            check($sformatf("v%0d_end_state", vi), 32'(dbg_state), 32'(IDLE));
        end
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    // Hard stop in case the DUT stalls a wait that the loops do not bound.
    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // Main sequence.
    initial begin
        int frame_len;
        frame_len = frame_bytes(N_REGS, N_MEM, NB_DATA, NB_B);
        // ready%, restartA, restartB, abort, rand, pc, bytes, done, latency
        vecs[0] = '{100, -1,  -1, -1, 1'b0, 32'h0000_0040, frame_len, 1, 389};
        vecs[1] = '{ 50, -1,  -1, -1, 1'b0, 32'h0000_0040, frame_len, 1,  -1};
        vecs[2] = '{100, 20, 150, -1, 1'b0, 32'h0000_0040, frame_len, 1, 389};
        vecs[3] = '{100, -1,  -1, 46, 1'b0, 32'h0000_0040,        46, 0,  -1};
        vecs[4] = '{100, -1,  -1, -1, 1'b0, 32'h0000_0040, frame_len, 1, 389};
        vecs[5] = '{ 60, -1,  -1, -1, 1'b1, $urandom,      frame_len, 1,  -1};
        vecs[6] = '{ 35, 30, 200, -1, 1'b1, $urandom,      frame_len, 1,  -1};

        // Reset held: everything quiet.
        rst = 1'b1; start = 1'b0; pc = '0;
        bus.tx_ready = 1'b0; bus.reg_data = '0; bus.mem_data = '0;
        repeat (3) @(negedge clk);
        check("rst_tx_valid", bus.tx_valid, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_reg_re", bus.reg_read_enable, 0);
        check("rst_reg_addr", 32'(bus.reg_addr), 0);
        check("rst_mem_re", bus.mem_read_enable, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));

        // Released with no start: stays idle.
        rst = 1'b0;
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_valid", bus.tx_valid, 0);
            check("idle_busy", busy, 0);
            check("idle_strobes", 32'(bus.reg_read_enable | bus.mem_read_enable), 0);
        end

        for (int vi = 0; vi < 7; vi++) run_vec(vecs[vi], vi);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
